// File: rtl/cmacc_seq.sv
// Job sequencer for one cmacc complex MAC: streams LEN operand pairs, aligns sload, drains, returns sum(a*b).
// Optional CMACC_SEQ_CONJ_EN: negate b imaginary (saturating) so the job returns sum(a*conj(b)).
//
// state | meaning
// IDLE  | waiting for start; cmacc not clocked
// RUN   | accepting operand pairs; mac_ce follows in_valid
// DRAIN | flushing the cmacc pipeline with zero operands, MAC_LAT-1 cycles
// CAPT  | mac_pr/mac_pi hold the final sum; copied into the result registers
// DONE  | result valid, waiting for res_ready
module cmacc_seq #(
  parameter int AWIDTH  = 16,
  parameter int BWIDTH  = 18,
  parameter int SIZEOUT = 40,
  parameter int LEN_W   = 12,
  parameter int MAC_LAT = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [AWIDTH-1:0]  in_ar,
  input  logic signed [AWIDTH-1:0]  in_ai,
  input  logic signed [BWIDTH-1:0]  in_br,
  input  logic signed [BWIDTH-1:0]  in_bi,
  output logic                      mac_ce,
  output logic                      mac_sload,
  output logic signed [AWIDTH-1:0]  mac_ar,
  output logic signed [AWIDTH-1:0]  mac_ai,
  output logic signed [BWIDTH-1:0]  mac_br,
  output logic signed [BWIDTH-1:0]  mac_bi,
  input  logic signed [SIZEOUT-1:0] mac_pr,
  input  logic signed [SIZEOUT-1:0] mac_pi,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [SIZEOUT-1:0] res_re,
  output logic signed [SIZEOUT-1:0] res_im
);

  localparam int IDX_W = $clog2(MAC_LAT);
  localparam logic [IDX_W-1:0] SLOAD_IDX = IDX_W'(MAC_LAT - 2);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CAPT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   rem_cnt;
  logic [IDX_W-1:0]   drain_cnt;
  logic [IDX_W-1:0]   ce_idx;
  logic               sload_done;
  logic signed [BWIDTH-1:0] bi_eff;

`ifdef CMACC_SEQ_CONJ_EN
  localparam logic signed [BWIDTH-1:0] B_MIN = {1'b1, {(BWIDTH-1){1'b0}}};
  localparam logic signed [BWIDTH-1:0] B_MAX = {1'b0, {(BWIDTH-1){1'b1}}};
  // the most negative code has no positive twin, so it clamps
  assign bi_eff = (in_bi == B_MIN) ? B_MAX : -in_bi;
`else
  assign bi_eff = in_bi;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (in_valid && rem_cnt == LEN_W'(1)) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_DONE;
      S_DONE:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    in_ready  = (state == S_RUN);
    res_valid = (state == S_DONE);
    mac_ce    = 1'b0;
    mac_ar    = '0;
    mac_ai    = '0;
    mac_br    = '0;
    mac_bi    = '0;
    case (state)
      S_RUN: begin
        mac_ce = in_valid;
        mac_ar = in_ar;
        mac_ai = in_ai;
        mac_br = in_br;
        mac_bi = bi_eff;
      end
      S_DRAIN: mac_ce = 1'b1;
      default: ;
    endcase
    // accumulator restarts exactly when the first product of this job reaches it
    mac_sload = mac_ce && (ce_idx == SLOAD_IDX) && !sload_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_cnt    <= '0;
      drain_cnt  <= '0;
      ce_idx     <= '0;
      sload_done <= 1'b0;
      res_re     <= '0;
      res_im     <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        rem_cnt    <= len;
        drain_cnt  <= SLOAD_IDX;
        ce_idx     <= '0;
        sload_done <= 1'b0;
        if (len == '0) begin
          res_re <= '0;
          res_im <= '0;
        end
      end
      if (mac_ce && ce_idx != SLOAD_IDX) ce_idx <= ce_idx + IDX_W'(1);
      if (mac_sload) sload_done <= 1'b1;
      if (state == S_RUN && in_valid) rem_cnt <= rem_cnt - LEN_W'(1);
      if (state == S_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - IDX_W'(1);
      if (state == S_CAPT) begin
        res_re <= mac_pr;
        res_im <= mac_pi;
      end
    end
  end

endmodule

// File: tb/tb_cmacc_seq.sv
// Bench for cmacc_seq: behavioural cmacc model, vector table of jobs, plus hold/len0/reset sequences.
module tb_cmacc_seq;
  localparam int AWIDTH  = 16;
  localparam int BWIDTH  = 18;
  localparam int SIZEOUT = 40;
  localparam int LEN_W   = 12;
  localparam int MAC_LAT = 6;
`ifdef CMACC_SEQ_CONJ_EN
  localparam bit CONJ = 1'b1;
`else
  localparam bit CONJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [LEN_W-1:0] len;
  logic busy, in_valid, in_ready, mac_ce, mac_sload, res_valid, res_ready;
  logic signed [AWIDTH-1:0]  in_ar, in_ai, mac_ar, mac_ai;
  logic signed [BWIDTH-1:0]  in_br, in_bi, mac_br, mac_bi;
  logic signed [SIZEOUT-1:0] mac_pr, mac_pi, res_re, res_im;

  always #5 clk = ~clk;

  cmacc_seq #(.AWIDTH(AWIDTH), .BWIDTH(BWIDTH), .SIZEOUT(SIZEOUT), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
    .mac_ce(mac_ce), .mac_sload(mac_sload),
    .mac_ar(mac_ar), .mac_ai(mac_ai), .mac_br(mac_br), .mac_bi(mac_bi),
    .mac_pr(mac_pr), .mac_pi(mac_pi),
    .res_valid(res_valid), .res_ready(res_ready), .res_re(res_re), .res_im(res_im)
  );

  // cmacc model: product of the edge-0 capture reaches the accumulator on ce edge MAC_LAT-1;
  // sload registered once and applied on the following accumulate. Never reset, starts dirty.
  logic signed [SIZEOUT-1:0] p_re [MAC_LAT-1] = '{default: 40'sd77};
  logic signed [SIZEOUT-1:0] p_im [MAC_LAT-1] = '{default: -40'sd55};
  logic                      s_q    = 1'b0;
  logic signed [SIZEOUT-1:0] acc_re = 40'sd12345;
  logic signed [SIZEOUT-1:0] acc_im = -40'sd999;
  logic signed [SIZEOUT-1:0] xar, xai, xbr, xbi, m_re, m_im;

  always_comb begin
    xar  = SIZEOUT'(mac_ar);
    xai  = SIZEOUT'(mac_ai);
    xbr  = SIZEOUT'(mac_br);
    xbi  = SIZEOUT'(mac_bi);
    m_re = xar * xbr - xai * xbi;
    m_im = xar * xbi + xai * xbr;
  end

  always @(posedge clk) begin
    if (mac_ce) begin
      p_re[0] <= m_re;
      p_im[0] <= m_im;
      for (int i = 1; i < MAC_LAT - 1; i++) begin
        p_re[i] <= p_re[i-1];
        p_im[i] <= p_im[i-1];
      end
      s_q    <= mac_sload;
      acc_re <= (s_q ? '0 : acc_re) + p_re[MAC_LAT-2];
      acc_im <= (s_q ? '0 : acc_im) + p_im[MAC_LAT-2];
    end
  end
  assign mac_pr = acc_re;
  assign mac_pi = acc_im;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef logic [3:0][31:0] ops_t;
  typedef struct {
    int     n;
    ops_t   ar, ai, br, bi;
    int     stall_at, stall_n;
    longint re, im, cre, cim;
  } vec_t;

  function automatic ops_t pk(input int x0, input int x1, input int x2, input int x3);
    ops_t r;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
    return r;
  endfunction

  ops_t   j_ar, j_ai, j_br, j_bi;
  longint r_re, r_im;
  int     r_lat, r_ce, r_sl;

  task automatic drive_op(input int k);
    in_ar = AWIDTH'($signed(j_ar[k]));
    in_ai = AWIDTH'($signed(j_ai[k]));
    in_br = BWIDTH'($signed(j_br[k]));
    in_bi = BWIDTH'($signed(j_bi[k]));
  endtask

  // Runs one job from the start pulse to res_valid; optionally completes the handshake.
  task automatic run_job(input int n, input int stall_at, input int stall_n, input bit hold);
    int sent, cyc, left;
    bit done;
    sent = 0; cyc = 0; left = stall_n; done = 0; r_ce = 0; r_sl = 0;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(n);
    while (!done && cyc < 300) begin
      @(negedge clk);
      start = 1'b0;
      len   = LEN_W'(5);
      if (res_valid) done = 1;
      else begin
        in_valid = 1'b0;
        in_ar = '0; in_ai = '0; in_br = '0; in_bi = '0;
        if (sent < n) begin
          if (sent == stall_at && left > 0) left--;
          else begin
            in_valid = 1'b1;
            drive_op(sent);
          end
        end
        #1;
        if (mac_ce) r_ce++;
        if (mac_sload) r_sl++;
        if (in_ready && !in_valid) chk("stall_ce", mac_ce, 0);
        if (in_valid && in_ready) sent++;
        cyc++;
      end
    end
    chk("job_done", done, 1);
    in_valid = 1'b0;
    r_lat = cyc;
    r_re  = res_re;
    r_im  = res_im;
    if (!hold) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("idle_after_ack", busy, 0);
    end
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{n:1, ar:pk(3,0,0,0), ai:pk(4,0,0,0), br:pk(5,0,0,0), bi:pk(-2,0,0,0),
               stall_at:-1, stall_n:0, re:23, im:14, cre:7, cim:26};
    tbl[1] = '{n:3, ar:pk(1,2,0,0), ai:pk(1,0,-1,0), br:pk(1,1,2,0), bi:pk(0,1,2,0),
               stall_at:1, stall_n:2, re:5, im:1, cre:1, cim:-3};
    tbl[2] = '{n:4, ar:pk(-100,7,0,-1), ai:pk(50,-3,0,-1), br:pk(10,-4,9,1000), bi:pk(20,5,9,-1000),
               stall_at:2, stall_n:1, re:-4013, im:-1453, cre:-43, cim:477};
    tbl[3] = '{n:2, ar:pk(-32768,-32768,0,0), ai:pk(-32768,-32768,0,0),
               br:pk(-131072,-131072,0,0), bi:pk(-131072,-131072,0,0),
               stall_at:-1, stall_n:0, re:0, im:64'sd17179869184,
               cre:64'sd17179803648, cim:65536};

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; res_ready = 1'b0;
    in_ar = 16'sd5; in_ai = '0; in_br = '0; in_bi = 18'sd9;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_re", res_re, 0);
    chk("rst_res_im", res_im, 0);
    chk("rst_mac_ce", mac_ce, 0);
    chk("rst_mac_sload", mac_sload, 0);
    chk("idle_mac_ar", mac_ar, 0);
    chk("idle_mac_bi", mac_bi, 0);
    @(negedge clk);
    rst = 1'b0;
    in_ar = '0; in_bi = '0;

    for (int v = 0; v < 4; v++) begin
      j_ar = tbl[v].ar; j_ai = tbl[v].ai; j_br = tbl[v].br; j_bi = tbl[v].bi;
      run_job(tbl[v].n, tbl[v].stall_at, tbl[v].stall_n, 1'b0);
      chk($sformatf("v%0d_re", v), r_re, CONJ ? tbl[v].cre : tbl[v].re);
      chk($sformatf("v%0d_im", v), r_im, CONJ ? tbl[v].cim : tbl[v].im);
      chk($sformatf("v%0d_lat", v), r_lat, tbl[v].n + tbl[v].stall_n + MAC_LAT);
      chk($sformatf("v%0d_ce_cnt", v), r_ce, tbl[v].n + MAC_LAT - 1);
      chk($sformatf("v%0d_sload_cnt", v), r_sl, 1);
    end

    // result held in DONE while start is pulsed; start on the handshake cycle ignored
    j_ar = pk(1,3,0,0); j_ai = pk(2,-1,0,0); j_br = pk(2,1,0,0); j_bi = pk(0,1,0,0);
    run_job(2, -1, 0, 1'b1);
    chk("hold_re", r_re, CONJ ? 4 : 6);
    chk("hold_im", r_im, CONJ ? 0 : 6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1;
      len   = LEN_W'(3);
      #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_re_stable", res_re, r_re);
      chk("hold_im_stable", res_im, r_im);
      chk("hold_ce", mac_ce, 0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    #1;
    chk("start_at_ack_ignored", busy, 0);
    j_ar = pk(1,0,0,0); j_ai = pk(0,0,0,0); j_br = pk(7,0,0,0); j_bi = pk(0,0,0,0);
    run_job(1, -1, 0, 1'b0);
    chk("job2_re", r_re, 7);
    chk("job2_im", r_im, 0);
    chk("job2_sload_cnt", r_sl, 1);

    run_job(0, -1, 0, 1'b0);
    chk("len0_lat", r_lat, 0);
    chk("len0_re", r_re, 0);
    chk("len0_im", r_im, 0);
    chk("len0_ce_cnt", r_ce, 0);

    // reset after 2 of 4 samples; also probes b-imag handling of the most negative code
    j_ar = pk(1,2,3,4); j_ai = pk(1,1,1,1); j_br = pk(5,6,7,8); j_bi = pk(1,2,3,4);
    @(negedge clk);
    start = 1'b1; len = LEN_W'(4);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; drive_op(0);
    @(negedge clk);
    drive_op(1);
    @(negedge clk);
    in_valid = 1'b0; in_ar = 16'sd2; in_br = 18'sd3; in_bi = -18'sd131072;
    #1;
    chk("run_mac_bi", mac_bi, CONJ ? 131071 : -131072);
    chk("run_mac_br", mac_br, 3);
    chk("run_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_mac_ce", mac_ce, 0);
    chk("midrst_mac_bi", mac_bi, 0);
    chk("midrst_res_re", res_re, 0);
    @(negedge clk);
    rst = 1'b0; in_ar = '0; in_br = '0; in_bi = '0;
    j_ar = pk(2,0,0,0); j_ai = pk(0,0,0,0); j_br = pk(3,0,0,0); j_bi = pk(0,0,0,0);
    run_job(1, -1, 0, 1'b0);
    chk("post_rst_re", r_re, 6);
    chk("post_rst_im", r_im, 0);
    chk("post_rst_lat", r_lat, 1 + MAC_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
